spi_ram_param: RTL and testbench
================================

Name: spi_ram_param

Overview:
- Parametrised successor to the 8-bit SPI-slave RAM. Sits behind the SPI slave, which decodes serial frames into {opcode, payload} words on din with an rx_valid strobe.
- Generalised in data width, address width and depth. Depth need not be a power of two.
- Adds independent write and read address pointers, sequential (burst) access, an out-of-range address error flag and a one-cycle tx_valid pulse.

Parameters:
- DATA_SIZE, 8, payload and memory word width in bits.
- ADDR_SIZE, 8, pointer width in bits. Must satisfy ADDR_SIZE <= DATA_SIZE.
- MEM_DEPTH, 256, number of words. Must satisfy 1 <= MEM_DEPTH <= 2**ADDR_SIZE.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst  in  1  asynchronous, active-high reset.
- din  in  DATA_SIZE+2  opcode din[DATA_SIZE+1:DATA_SIZE], payload din[DATA_SIZE-1:0].
- rx_valid  in  1  qualifies din for one cycle; din is ignored when low.
- dout  out  DATA_SIZE  read data; holds its value between reads.
- tx_valid  out  1  one-cycle pulse when dout is updated by a read.
- addr_err  out  1  one-cycle pulse when an address command is out of range.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr=0, rd_ptr=0, dout=0, tx_valid=0, addr_err=0.
  - Memory array is not reset; contents are retained across reset.
- All commands act on the rising edge where rx_valid=1. With rx_valid=0 there is no state change, and tx_valid/addr_err drop to 0 on the next edge.
- Opcode 00, write address:
  - If payload[ADDR_SIZE-1:0] < MEM_DEPTH and payload bits above ADDR_SIZE are 0, then wr_ptr <= payload.
  - Otherwise wr_ptr is unchanged and addr_err=1 for one cycle.
- Opcode 01, write data:
  - MEM[wr_ptr] <= payload.
  - Then wr_ptr advances (see Optional Feature).
- Opcode 10, read address: same range check and addr_err rule as opcode 00, applied to rd_ptr.
- Opcode 11, read data:
  - dout <= MEM[rd_ptr] and tx_valid=1 on the same edge, i.e. registered with 1-cycle latency from the command edge.
  - Payload is don't-care.
  - Then rd_ptr advances (see Optional Feature).
- tx_valid and addr_err are registered pulses. They are high exactly one cycle per qualifying command and 0 on every other cycle.
- Pointer wrap: on advance, a pointer equal to MEM_DEPTH-1 becomes 0. Otherwise it increments by 1.
- Read-after-write: a read data command issued on any cycle after a write data to the same address returns the new value. No same-cycle collision is possible because there is one command per cycle.
- Reset mid-burst clears the pointers immediately. The next write data without a prior write address targets address 0.
- dout is never cleared except by reset.

Optional Feature:
- Macro: SPI_RAM_AUTO_INC_EN.
- Defined: wr_ptr advances after every write data and rd_ptr advances after every read data, with wrap at MEM_DEPTH-1. This supports burst access with one address command.
- Undefined: pointers change only on address commands. Repeated data commands hit the same address, which is the legacy behaviour.

Test Plan:
- rx_valid=0 for 200 cycles of mixed opcodes with random payloads -> dout=0, tx_valid=0, addr_err=0, memory unchanged.
- Write-address 0x10, write-data 0xA5, read-address 0x10, read-data -> dout=0xA5. tx_valid high only on the cycle after the read-data edge.
- With SPI_RAM_AUTO_INC_EN and MEM_DEPTH=200:
  - Stimulus: write-address 198, write-data 0x11/0x22/0x33; read-address 198, three read-data commands.
  - Response: dout sequence 0x11, 0x22, 0x33. The third write lands at address 0 through wrap.
- MEM_DEPTH=200: write-address 250 -> addr_err=1 for one cycle and wr_ptr unchanged. A following write-data 0x5A then a read back of the previous pointer returns 0x5A.
- Burst sequence:
  - Stimulus: write 8 words, assert rst for 1 cycle mid-burst after word 4, then read-data at address 0 without a read-address command.
  - Response: pointers reset to 0, dout=0 on reset; the read returns word 0 written before reset, since memory is retained.
- Without the macro: write-address 0x05, write-data 0x01 then 0x02, read-address 0x05, read-data twice -> dout=0x02 both times, two tx_valid pulses.

Source files
------------

// File: rtl/spi_ram_param_if.sv
// Command/response bundle between the SPI slave frame decoder and spi_ram_param.
// master drives framed commands; slave returns read data and one-cycle status pulses.
interface spi_ram_param_if #(
  parameter int DATA_SIZE = 8
);
  logic [DATA_SIZE+1:0] din;
  logic                 rx_valid;
  logic [DATA_SIZE-1:0] dout;
  logic                 tx_valid;
  logic                 addr_err;

  modport master (output din, rx_valid, input dout, tx_valid, addr_err);
  modport slave  (input din, rx_valid, output dout, tx_valid, addr_err);
endinterface

// File: rtl/spi_ram_param.sv
// Parametrised SPI-slave RAM with separate write/read pointers; SPI_RAM_AUTO_INC_EN enables burst pointer advance.
// Read data and status pulses register one cycle after the command edge; no backpressure, one command per rx_valid cycle.
module spi_ram_param #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256
) (
  input logic            clk,
  input logic            rst,
  spi_ram_param_if.slave bus
);

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_SIZE:0]   DEPTH_W  = (ADDR_SIZE+1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST_PTR = ADDR_SIZE'(MEM_DEPTH - 1);

`ifdef SPI_RAM_AUTO_INC_EN
  localparam logic AUTO_INC = 1'b1;
`else
  localparam logic AUTO_INC = 1'b0;
`endif

  logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

  logic [1:0]           opcode;
  logic [DATA_SIZE-1:0] payload;
  logic [ADDR_SIZE-1:0] payload_addr;
  logic                 addr_ok;

  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [DATA_SIZE-1:0] dout_q;
  logic                 tx_valid_q;
  logic                 addr_err_q;

  assign opcode       = bus.din[DATA_SIZE+1:DATA_SIZE];
  assign payload      = bus.din[DATA_SIZE-1:0];
  assign payload_addr = payload[ADDR_SIZE-1:0];
  // Any set bit above the pointer field makes the address out of range.
  assign addr_ok      = ({1'b0, payload_addr} < DEPTH_W) && ((payload >> ADDR_SIZE) == '0);

  function automatic logic [ADDR_SIZE-1:0] next_ptr(input logic [ADDR_SIZE-1:0] p);
    next_ptr = (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      tx_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
      if (bus.rx_valid) begin
        case (opcode)
          OP_WR_ADDR: begin
            if (addr_ok) wr_ptr <= payload_addr;
            else         addr_err_q <= 1'b1;
          end
          OP_WR_DATA: begin
            if (AUTO_INC) wr_ptr <= next_ptr(wr_ptr);
          end
          OP_RD_ADDR: begin
            if (addr_ok) rd_ptr <= payload_addr;
            else         addr_err_q <= 1'b1;
          end
          default: begin
            dout_q     <= mem[rd_ptr[IDX_W-1:0]];
            tx_valid_q <= 1'b1;
            if (AUTO_INC) rd_ptr <= next_ptr(rd_ptr);
          end
        endcase
      end
    end
  end

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (!rst && bus.rx_valid && opcode == OP_WR_DATA) begin
      mem[wr_ptr[IDX_W-1:0]] <= payload;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_spi_ram_param.sv
// Scoreboard bench for spi_ram_param: a behavioural RAM model predicts each pulse and its cycle, a monitor checks outputs every cycle.
module tb_spi_ram_param;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 200;

`ifdef SPI_RAM_AUTO_INC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_ram_param_if #(.DATA_SIZE(DW)) bus ();

  spi_ram_param #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .MEM_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int          cyc;
    bit          is_rd;
    bit          known;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_known [DEPTH];
  int            m_wr = 0;
  int            m_rd = 0;

  always @(posedge clk) cyc++;

  task automatic model(input logic [1:0] op, input logic [DW-1:0] pl, input int at);
    exp_t e;
    e.cyc = at; e.is_rd = 1'b0; e.known = 1'b0; e.data = '0;
    case (op)
      2'd0: if (int'(pl) < DEPTH) m_wr = int'(pl); else sb.push_back(e);
      2'd1: begin
        m_mem[m_wr] = pl; m_known[m_wr] = 1'b1;
        if (AUTO) m_wr = (m_wr + 1) % DEPTH;
      end
      2'd2: if (int'(pl) < DEPTH) m_rd = int'(pl); else sb.push_back(e);
      default: begin
        e.is_rd = 1'b1; e.known = m_known[m_rd]; e.data = m_mem[m_rd];
        sb.push_back(e);
        if (AUTO) m_rd = (m_rd + 1) % DEPTH;
      end
    endcase
  endtask

  task automatic send(input bit vld, input logic [1:0] op, input logic [DW-1:0] pl);
    @(posedge clk); #1;
    bus.rx_valid = vld;
    bus.din      = {op, pl};
    if (vld) model(op, pl, cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 2'($urandom_range(0, 3)), DW'($urandom));
  endtask

  task automatic pulse_reset();
    idle(1);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    m_wr = 0; m_rd = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: pops one expectation per observed pulse, otherwise checks dout holds.
  logic [DW-1:0] held = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      checks++;
      if (bus.dout !== '0 || bus.tx_valid !== 1'b0 || bus.addr_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dout=%h tx=%b err=%b required 00 0 0", bus.dout, bus.tx_valid, bus.addr_err);
      end
      held = '0;
    end else begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        checks++; errors++;
        $display("FAIL missing_pulse cycle=%0d is_rd=%b got no pulse", e.cyc, e.is_rd);
      end
      if (bus.tx_valid || bus.addr_err) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_pulse cycle=%0d tx=%b err=%b required none", cyc, bus.tx_valid, bus.addr_err);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || bus.tx_valid !== e.is_rd || bus.addr_err !== !e.is_rd) begin
            errors++;
            $display("FAIL pulse cycle=%0d tx=%b err=%b required cycle=%0d tx=%b err=%b",
                     cyc, bus.tx_valid, bus.addr_err, e.cyc, e.is_rd, !e.is_rd);
          end
          if (e.is_rd && e.known) begin
            checks++;
            if (bus.dout !== e.data) begin
              errors++;
              $display("FAIL read_data cycle=%0d dout=%h required %h", cyc, bus.dout, e.data);
            end
          end
        end
        if (bus.tx_valid) held = bus.dout;
      end else begin
        checks++;
        if (bus.dout !== held) begin
          errors++;
          $display("FAIL dout_hold cycle=%0d dout=%h required %h", cyc, bus.dout, held);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout cycle=%0d required finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int prev;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    bus.rx_valid = 1'b0;
    bus.din      = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic write/read
    send(1, 2'd0, 8'h10); send(1, 2'd1, 8'hA5);
    send(1, 2'd2, 8'h10); send(1, 2'd3, 8'h00);

    // Idle traffic must not disturb anything
    idle(200);
    send(1, 2'd2, 8'h10); send(1, 2'd3, 8'h3C);

    // Wrap at DEPTH-1
    send(1, 2'd0, 8'd198);
    send(1, 2'd1, 8'h11); send(1, 2'd1, 8'h22); send(1, 2'd1, 8'h33);
    send(1, 2'd2, 8'd198);
    send(1, 2'd3, 8'h00); send(1, 2'd3, 8'h00); send(1, 2'd3, 8'h00);

    // Out-of-range address leaves the pointer alone
    prev = m_wr;
    send(1, 2'd0, 8'd250); send(1, 2'd1, 8'h5A);
    send(1, 2'd2, 8'(prev)); send(1, 2'd3, 8'h00);
    send(1, 2'd2, 8'd200); send(1, 2'd0, 8'd199); send(1, 2'd2, 8'd255);

    // Repeated data commands at one address
    send(1, 2'd0, 8'h05); send(1, 2'd1, 8'h01); send(1, 2'd1, 8'h02);
    send(1, 2'd2, 8'h05); send(1, 2'd3, 8'h00); send(1, 2'd3, 8'h00);

    // Burst interrupted by reset; memory survives, pointers restart at 0
    send(1, 2'd0, 8'h00);
    for (int i = 0; i < 4; i++) send(1, 2'd1, 8'(8'hC0 + i));
    pulse_reset();
    send(1, 2'd3, 8'h00);
    for (int i = 4; i < 8; i++) send(1, 2'd1, 8'(8'hC0 + i));
    send(1, 2'd3, 8'h00); send(1, 2'd3, 8'h00);

    // Random mix
    for (int i = 0; i < 600; i++) begin
      send(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), DW'($urandom_range(0, 255)));
    end

    idle(5);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
